// File: rtl/aclk_pkg.sv
// Shared types and helpers for the multi-alarm clock.
//   bcd_time_t   : packed BCD time h1:h0:m1:m0:s1:s0 (h1 is 2 bits wide)
//   chan_state_t : per-channel alarm state (idle / ringing)
//   hm_valid()   : legality check for a loaded HH:MM digit set
//   bcd_inc()    : one-second BCD increment with full carry chain
package aclk_pkg;

  localparam int HOUR_MAX  = 23;
  localparam int MIN_MAX   = 59;
  localparam int DIGIT_MAX = 9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_RINGING = 1'b1
  } chan_state_t;

  // Every digit must be a decimal digit and the decoded hour/minute must be
  // in range; h1 is only 2 bits so the hour bound covers it.
  function automatic logic hm_valid(input logic [1:0] h1, input logic [3:0] h0,
                                    input logic [3:0] m1, input logic [3:0] m0);
    int hour;
    int minute;
    hour   = int'(h1) * 10 + int'(h0);
    minute = int'(m1) * 10 + int'(m0);
    return (int'(h0) <= DIGIT_MAX) && (int'(m1) <= DIGIT_MAX) &&
           (int'(m0) <= DIGIT_MAX) && (hour <= HOUR_MAX) && (minute <= MIN_MAX);
  endfunction

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s0 != 4'(DIGIT_MAX)) begin
      r.s0 = t.s0 + 4'd1;
    end else begin
      r.s0 = '0;
      if (t.s1 != 4'(MIN_MAX / 10)) begin
        r.s1 = t.s1 + 4'd1;
      end else begin
        r.s1 = '0;
        if (t.m0 != 4'(DIGIT_MAX)) begin
          r.m0 = t.m0 + 4'd1;
        end else begin
          r.m0 = '0;
          if (t.m1 != 4'(MIN_MAX / 10)) begin
            r.m1 = t.m1 + 4'd1;
          end else begin
            r.m1 = '0;
            if (t.h1 == 2'(HOUR_MAX / 10) && t.h0 == 4'(HOUR_MAX % 10)) begin
              r.h1 = '0;
              r.h0 = '0;
            end else if (t.h0 == 4'(DIGIT_MAX)) begin
              r.h0 = '0;
              r.h1 = t.h1 + 2'd1;
            end else begin
              r.h0 = t.h0 + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aclk_alarm_chan.sv
// One alarm channel: stored HH:MM, match detection, idle/ringing FSM and
// ring-duration counter.
// Ports:
//   clk, reset      : clock, async active-high reset
//   ld              : load alarm from h1/h0/m1/m0 (already validated/selected)
//   h1,h0,m1,m0     : BCD alarm digits
//   en              : channel armed
//   stop            : silence request
//   tick            : one-second strobe (this cycle)
//   upd             : time registers were written on the previous edge
//   now             : current time registers
//   ring            : high while the channel is ringing
module aclk_alarm_chan
  import aclk_pkg::*;
#(
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [1:0] h1,
  input  logic [3:0] h0,
  input  logic [3:0] m1,
  input  logic [3:0] m0,
  input  logic       en,
  input  logic       stop,
  input  logic       tick,
  input  logic       upd,
  input  bcd_time_t  now,
  output logic       ring
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  logic [1:0]  al_h1;
  logic [3:0]  al_h0;
  logic [3:0]  al_m1;
  logic [3:0]  al_m0;
  chan_state_t state;
  chan_state_t state_nx;
  logic [7:0]  ring_cnt;
  logic        match;
  logic        ring_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_h1 <= '0;
      al_h0 <= '0;
      al_m1 <= '0;
      al_m0 <= '0;
    end else if (ld) begin
      al_h1 <= h1;
      al_h0 <= h0;
      al_m1 <= m1;
      al_m0 <= m0;
    end
  end

  // Only a fresh write of the time registers (tick or load) can match, so a
  // time value that merely sits at HH:MM:00 (e.g. after reset) never fires.
  assign match = upd && en && (now.s1 == 4'd0) && (now.s0 == 4'd0) &&
                 (now.h1 == al_h1) && (now.h0 == al_h0) &&
                 (now.m1 == al_m1) && (now.m0 == al_m0);

  assign ring_done = tick && (ring_cnt == RING_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CH_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CH_IDLE:    if (match && !stop) state_nx = CH_RINGING;
      CH_RINGING: if (stop || !en || ring_done) state_nx = CH_IDLE;
      default:    state_nx = CH_IDLE;
    endcase
  end

  // Counts ticks spent ringing; re-entering from idle always starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ring_cnt <= '0;
    end else if (state == CH_IDLE) begin
      ring_cnt <= '0;
    end else if (tick) begin
      ring_cnt <= ring_cnt + 8'd1;
    end
  end

  assign ring = (state == CH_RINGING);

endmodule

// File: rtl/aclk_multi_alarm.sv
// 24-hour BCD clock with NUM_ALARMS independent alarm channels.
// Ports:
//   clk, reset                 : clock (CLK_DIV cycles per second), async active-high reset
//   H_in1,H_in0,M_in1,M_in0    : BCD load digits shared by time and alarm loads
//   LD_time                    : load clock HH:MM (seconds -> 00, prescaler -> 0)
//   LD_alarm, AL_sel           : load alarm[AL_sel] HH:MM
//   AL_en                      : per-channel arm enable
//   STOP_al                    : silence all ringing channels
//   H_out1..S_out0             : current time, BCD
//   Alarm                      : per-channel ringing flag
module aclk_multi_alarm
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS = 2,
  parameter int CLK_DIV    = 10,
  parameter int RING_SECS  = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] AL_sel,
  input  logic [NUM_ALARMS-1:0] AL_en,
  input  logic                  STOP_al,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic [NUM_ALARMS-1:0] Alarm
);

  localparam int             PRE_W    = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]      pre_cnt;
  logic                  tick;
  logic                  in_ok;
  logic                  ld_time_ok;
  logic                  ld_alarm_ok;
  logic [NUM_ALARMS-1:0] ld_chan;
  bcd_time_t             tm_load;
  bcd_time_t             tm_p1;
  logic                  vld_p1;

  assign tick        = (pre_cnt == PRE_LAST);
  assign in_ok       = hm_valid(H_in1, H_in0, M_in1, M_in0);
  assign ld_time_ok  = LD_time && in_ok;
  assign ld_alarm_ok = LD_alarm && in_ok && (int'(AL_sel) < NUM_ALARMS);

  always_comb begin
    tm_load    = '0;
    tm_load.h1 = H_in1;
    tm_load.h0 = H_in0;
    tm_load.m1 = M_in1;
    tm_load.m0 = M_in0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (ld_time_ok || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Stage p1: time registers plus a strobe marking that they were just
  // written; the channels compare against this stage, so a ring starts one
  // cycle after the matching time appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tm_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ld_time_ok || tick;
      if (ld_time_ok) begin
        tm_p1 <= tm_load;
      end else if (tick) begin
        tm_p1 <= bcd_inc(tm_p1);
      end
    end
  end

  assign H_out1 = tm_p1.h1;
  assign H_out0 = tm_p1.h0;
  assign M_out1 = tm_p1.m1;
  assign M_out0 = tm_p1.m0;
  assign S_out1 = tm_p1.s1;
  assign S_out0 = tm_p1.s0;

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_chan
    assign ld_chan[k] = ld_alarm_ok && (int'(AL_sel) == k);

    aclk_alarm_chan #(
      .RING_SECS(RING_SECS)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .ld   (ld_chan[k]),
      .h1   (H_in1),
      .h0   (H_in0),
      .m1   (M_in1),
      .m0   (M_in0),
      .en   (AL_en[k]),
      .stop (STOP_al),
      .tick (tick),
      .upd  (vld_p1),
      .now  (tm_p1),
      .ring (Alarm[k])
    );
  end

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// Bench for aclk_multi_alarm: directed scenarios followed by random loads,
// each cycle compared to a seconds-of-day reference model.
module tb_aclk_multi_alarm;

  localparam int NUM_ALARMS = 2;
  localparam int CLK_DIV    = 10;
  localparam int RING_SECS  = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm;
  logic [0:0] AL_sel;
  logic [1:0] AL_en;
  logic       STOP_al;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;
  logic [1:0] Alarm;
  logic [21:0] dut_tm;

  aclk_multi_alarm #(
    .NUM_ALARMS(NUM_ALARMS), .CLK_DIV(CLK_DIV), .RING_SECS(RING_SECS)
  ) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .AL_sel(AL_sel), .AL_en(AL_en),
    .STOP_al(STOP_al),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .Alarm(Alarm)
  );

  always #5 clk = ~clk;

  assign dut_tm = {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

  int errors = 0;
  int checks = 0;

  // Reference model: time as seconds of day, alarms as minutes of day,
  // each ringing channel holds the number of ticks it has left.
  int m_sec;
  int m_pre;
  bit m_upd;
  int m_al   [NUM_ALARMS];
  bit m_ring [NUM_ALARMS];
  int m_left [NUM_ALARMS];

  function automatic logic [21:0] enc(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit dig_ok(input int h1, input int h0, input int m1, input int m0);
    return (h0 <= 9) && (m1 <= 9) && (m0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 * 10 + m0 <= 59);
  endfunction

  function automatic logic [21:0] model_tm();
    return enc(m_sec / 3600, (m_sec / 60) % 60, m_sec % 60);
  endfunction

  function automatic logic [1:0] model_al();
    logic [1:0] v;
    v = '0;
    for (int k = 0; k < NUM_ALARMS; k++) v[k] = m_ring[k];
    return v;
  endfunction

  task automatic model_reset();
    m_sec = 0;
    m_pre = 0;
    m_upd = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      m_al[k] = 0;
      m_ring[k] = 1'b0;
      m_left[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit ok;
    int in_h;
    int in_m;
    tick = (m_pre == CLK_DIV - 1);
    in_h = int'(H_in1) * 10 + int'(H_in0);
    in_m = int'(M_in1) * 10 + int'(M_in0);
    ok   = dig_ok(int'(H_in1), int'(H_in0), int'(M_in1), int'(M_in0));
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (!m_ring[k]) begin
        if (m_upd && AL_en[k] && (m_sec % 60 == 0) && (m_sec / 60 == m_al[k]) && !STOP_al) begin
          m_ring[k] = 1'b1;
          m_left[k] = RING_SECS;
        end
      end else if (STOP_al || !AL_en[k]) begin
        m_ring[k] = 1'b0;
      end else if (tick) begin
        m_left[k]--;
        if (m_left[k] == 0) m_ring[k] = 1'b0;
      end
    end
    if (LD_alarm && ok && int'(AL_sel) < NUM_ALARMS) m_al[int'(AL_sel)] = in_h * 60 + in_m;
    if (LD_time && ok) begin
      m_sec = in_h * 3600 + in_m * 60;
      m_pre = 0;
      m_upd = 1'b1;
    end else if (tick) begin
      m_sec = (m_sec + 1) % 86400;
      m_pre = 0;
      m_upd = 1'b1;
    end else begin
      m_pre++;
      m_upd = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_time", 32'(dut_tm), 32'(model_tm()));
    chk("model_alarm", 32'(Alarm), 32'(model_al()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_hm(input int h, input int m);
    H_in1 = 2'(h / 10);
    H_in0 = 4'(h % 10);
    M_in1 = 4'(m / 10);
    M_in0 = 4'(m % 10);
  endtask

  task automatic load_time(input int h, input int m);
    set_hm(h, m);
    LD_time = 1'b1;
    cyc();
    LD_time = 1'b0;
  endtask

  task automatic load_alarm(input int sel, input int h, input int m);
    set_hm(h, m);
    AL_sel = 1'(sel);
    LD_alarm = 1'b1;
    cyc();
    LD_alarm = 1'b0;
  endtask

  initial begin
    int r;
    reset = 1'b1;
    H_in1 = '0; H_in0 = '0; M_in1 = '0; M_in0 = '0;
    LD_time = 1'b0; LD_alarm = 1'b0; AL_sel = '0; AL_en = '0; STOP_al = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_time", 32'(dut_tm), 32'(enc(0, 0, 0)));
    chk("reset_alarm", 32'(Alarm), 32'(0));
    reset = 1'b0;

    // 600 seconds from reset
    run(600 * CLK_DIV);
    chk("t600_time", 32'(dut_tm), 32'(enc(0, 10, 0)));
    chk("t600_alarm", 32'(Alarm), 32'(0));

    // midnight rollover
    load_time(23, 59);
    chk("ld_2359", 32'(dut_tm), 32'(enc(23, 59, 0)));
    run(60 * CLK_DIV);
    chk("rollover", 32'(dut_tm), 32'(enc(0, 0, 0)));

    // invalid loads leave time and prescaler alone
    H_in1 = 2'd2; H_in0 = 4'd5; M_in1 = 4'd0; M_in0 = 4'd0;
    LD_time = 1'b1;
    cyc();
    chk("inv_hour25", 32'(dut_tm), 32'(enc(0, 0, 0)));
    H_in1 = 2'd0; H_in0 = 4'd1; M_in1 = 4'd0; M_in0 = 4'd10;
    cyc();
    LD_time = 1'b0;
    chk("inv_min_digit", 32'(dut_tm), 32'(enc(0, 0, 0)));
    run(CLK_DIV - 3);
    chk("inv_pre_kept_a", 32'(dut_tm), 32'(enc(0, 0, 0)));
    cyc();
    chk("inv_pre_kept_b", 32'(dut_tm), 32'(enc(0, 0, 1)));

    // channel 1 at 07:30, auto-stop after RING_SECS ticks
    AL_en = 2'b10;
    load_alarm(1, 7, 30);
    load_time(7, 29);
    run(60 * CLK_DIV);
    chk("a730_time", 32'(dut_tm), 32'(enc(7, 30, 0)));
    chk("a730_pre", 32'(Alarm), 32'(0));
    cyc();
    chk("a730_ring", 32'(Alarm), 32'(2'b10));
    run(RING_SECS * CLK_DIV - 2);
    chk("a730_still", 32'(Alarm), 32'(2'b10));
    cyc();
    chk("a730_auto_off", 32'(Alarm), 32'(0));
    chk("a730_end_time", 32'(dut_tm), 32'(enc(7, 31, 0)));

    // simultaneous time+alarm load triggers, then stop
    set_hm(9, 0);
    AL_sel = 1'b1;
    LD_time = 1'b1;
    LD_alarm = 1'b1;
    cyc();
    LD_time = 1'b0;
    LD_alarm = 1'b0;
    cyc();
    chk("both_load_ring", 32'(Alarm), 32'(2'b10));
    STOP_al = 1'b1;
    cyc();
    STOP_al = 1'b0;
    chk("both_load_stop", 32'(Alarm), 32'(0));

    // both channels at 06:00, stop at 06:00:05
    load_alarm(0, 6, 0);
    load_alarm(1, 6, 0);
    AL_en = 2'b11;
    load_time(5, 59);
    run(60 * CLK_DIV);
    chk("a600_time", 32'(dut_tm), 32'(enc(6, 0, 0)));
    cyc();
    chk("a600_ring", 32'(Alarm), 32'(2'b11));
    run(5 * CLK_DIV - 1);
    chk("a600_t5", 32'(dut_tm), 32'(enc(6, 0, 5)));
    chk("a600_t5_ring", 32'(Alarm), 32'(2'b11));
    STOP_al = 1'b1;
    cyc();
    STOP_al = 1'b0;
    chk("a600_stopped", 32'(Alarm), 32'(0));

    // load-triggered ring; reload does not stop; disabling stops one channel
    load_time(6, 0);
    cyc();
    chk("ldtrig_ring", 32'(Alarm), 32'(2'b11));
    load_alarm(0, 12, 0);
    chk("reload_keeps", 32'(Alarm), 32'(2'b11));
    AL_en = 2'b01;
    cyc();
    chk("disable_ch1", 32'(Alarm), 32'(2'b01));
    STOP_al = 1'b1;
    cyc();
    STOP_al = 1'b0;
    chk("stop_ch0", 32'(Alarm), 32'(0));

    // stop coincident with a new match keeps the channel idle
    AL_en = 2'b11;
    load_alarm(0, 6, 0);
    load_time(6, 0);
    STOP_al = 1'b1;
    cyc();
    STOP_al = 1'b0;
    chk("stop_wins", 32'(Alarm), 32'(0));
    run(5);
    chk("stop_wins_hold", 32'(Alarm), 32'(0));

    // reset while ringing
    AL_en = 2'b01;
    load_alarm(0, 8, 15);
    load_time(8, 15);
    cyc();
    chk("pre_reset_ring", 32'(Alarm), 32'(2'b01));
    reset = 1'b1;
    #1;
    chk("reset_mid_time", 32'(dut_tm), 32'(enc(0, 0, 0)));
    chk("reset_mid_alarm", 32'(Alarm), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    run(CLK_DIV - 1);
    chk("first_tick_before", 32'(dut_tm), 32'(enc(0, 0, 0)));
    cyc();
    chk("first_tick_at", 32'(dut_tm), 32'(enc(0, 0, 1)));
    run(300);
    chk("no_ring_after_reset", 32'(Alarm), 32'(0));

    // random loads, enables and stops against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      LD_time  = (r < 4);
      LD_alarm = (r >= 3 && r < 8);
      STOP_al  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) AL_en = 2'($urandom);
      AL_sel = 1'($urandom);
      case ($urandom_range(0, 9))
        0: begin H_in1 = 2'd2; H_in0 = 4'($urandom_range(4, 15)); M_in1 = 4'd0; M_in0 = 4'd0; end
        1: begin H_in1 = 2'd0; H_in0 = 4'd1; M_in1 = 4'd0; M_in0 = 4'($urandom_range(10, 15)); end
        2: begin H_in1 = 2'($urandom_range(0, 3)); H_in0 = 4'd0; M_in1 = 4'($urandom_range(6, 15)); M_in0 = 4'd0; end
        default: begin
          r = int'($urandom_range(0, 2));
          set_hm((r == 2) ? 23 : r, 0);
          r = int'($urandom_range(0, 2));
          M_in1 = (r == 2) ? 4'd5 : 4'd0;
          M_in0 = (r == 2) ? 4'd9 : 4'(r);
        end
      endcase
      cyc();
    end
    LD_time = 1'b0;
    LD_alarm = 1'b0;
    STOP_al = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aclk_multi_alarm.md
ACLK_MULTI_ALARM -- requirements
Module: aclk_multi_alarm

Interface
REQ-001 Parameter NUM_ALARMS, default 2, number of independent alarm channels (1..8).
REQ-002 Parameter CLK_DIV, default 10, clk cycles per real-time second (>=2).
REQ-003 Parameter RING_SECS, default 60, seconds an alarm rings before auto-stop (1..255).
REQ-004 clk  in  1  clock, CLK_DIV cycles per second.
REQ-005 reset  in  1  asynchronous, active-high; clears time, all alarms, all ring state.
REQ-006 H_in1  in  2 / H_in0  in  4 / M_in1  in  4 / M_in0  in  4  BCD hour/minute digits for loading.
REQ-007 LD_time  in  1  load clock time from *_in digits.
REQ-008 LD_alarm  in  1  load alarm[AL_sel] from *_in digits.
REQ-009 AL_sel  in  $clog2(NUM_ALARMS) (min 1)  alarm channel selected for LD_alarm.
REQ-010 AL_en  in  NUM_ALARMS  per-channel arm enable.
REQ-011 STOP_al  in  1  silence all ringing channels.
REQ-012 H_out1  out  2 / H_out0, M_out1, M_out0, S_out1, S_out0  out  4  current time, BCD.
REQ-013 Alarm  out  NUM_ALARMS  per-channel ringing flag.

Function
REQ-014 Prescaler counts 0..CLK_DIV-1; tick is the cycle it equals CLK_DIV-1; it then wraps to 0.
REQ-015 On tick, seconds increment in BCD: S_out0 9->0 carries to S_out1; 59->00 carries to minutes; minutes 59->00 carry to hours; 23:59:59 -> 00:00:00.
REQ-016 LD_time high at a clk edge loads H:M from inputs, sets seconds to 00, clears prescaler; LD_time overrides a coincident tick.
REQ-017 Load digits are valid only if hour <= 23, minute <= 59 and every digit <= 9; an invalid LD_time or LD_alarm is discarded with no state change.
REQ-018 LD_alarm loads alarm[AL_sel] hour/minute; AL_sel >= NUM_ALARMS discards the load.
REQ-019 LD_time and LD_alarm in the same cycle both take effect.
REQ-020 Each channel is a two-state FSM: IDLE, RINGING.
REQ-021 IDLE -> RINGING on the cycle after time registers become HH:MM:00 equal to alarm[k] with AL_en[k] high; a match caused by LD_time also triggers.
REQ-022 RINGING -> IDLE on STOP_al high, AL_en[k] low, or after RING_SECS ticks in RINGING; Alarm[k] high exactly in RINGING.
REQ-023 STOP_al coincident with a new match wins: channel stays IDLE.
REQ-024 Reloading alarm[k] while RINGING does not stop the ring.
REQ-025 Channels are independent; several may ring simultaneously.

Reset
REQ-026 On reset: time 00:00:00, all alarms 00:00, prescaler 0, all channels IDLE, Alarm all 0.
REQ-027 Reset asserted mid-ring or mid-load clears immediately; first tick occurs CLK_DIV cycles after deassertion.
REQ-028 A post-reset 00:00:00 does not trigger alarms until a tick or load produces a match.

Structure
REQ-029 Package aclk_pkg holds the BCD time struct (h1,h0,m1,m0,s1,s0), limit constants (23, 59, 9) and the channel state enum.
REQ-030 Sub-module aclk_alarm_chan implements one channel (alarm storage, compare, FSM, ring counter), instantiated NUM_ALARMS times via generate.

Verification
REQ-031 Reset, run 600 ticks -> outputs 00:10:00; Alarm stays 0.
REQ-032 LD_time 23:59, run 60 ticks -> 00:00:00, all carries correct.
REQ-033 LD_alarm sel 1 = 07:30, AL_en=2'b10, LD_time 07:29, 60 ticks -> Alarm=2'b10 one cycle after 07:30:00; auto-clears after 60 ticks.
REQ-034 LD_time H_in1=2,H_in0=5 (25:00) or M_in0=10 -> time unchanged.
REQ-035 Both alarms 06:00, both enabled, STOP_al pulse at 06:00:05 -> Alarm 2'b11 then 2'b00.
REQ-036 Reset asserted while Alarm=2'b01 -> Alarm 0 and time 00:00:00 immediately, no ring after release.
